// File: rtl/counter_mod.sv
// Up/down modulo counter with programmable terminal value, wrap/saturate mode,
// synchronous load, an integrated prescaler and a sticky bound-hit flag.
module counter_mod #(
   parameter int BW       = 4,
   parameter int PRESC_BW = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                up_i,
   input  logic                sat_i,
   input  logic                load_i,
   input  logic [BW-1:0]       load_val_i,
   input  logic [BW-1:0]       max_i,
   input  logic [PRESC_BW-1:0] presc_i,
   input  logic                clr_ovf_i,
   output logic [BW-1:0]       count_o,
   output logic                tick_o,
   output logic                wrap_o,
   output logic                ovf_o
);

   logic [BW-1:0]       count_q, count_d;
   logic [PRESC_BW-1:0] presc_q, presc_d;
   logic                tick_q, tick_d;
   logic                wrap_q, wrap_d;
   logic                ovf_q, ovf_d;
   logic                step_s;
   logic                hit_s;

   // Next-state: load beats step; prescaler gates steps; bound handling per direction
   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      step_s  = 1'b0;
      hit_s   = 1'b0;

      if (load_i) begin
         count_d = (load_val_i > max_i) ? max_i : load_val_i;
         presc_d = '0;
      end else if (en_i) begin
         if (presc_q >= presc_i) begin
            step_s  = 1'b1;
            presc_d = '0;
         end else begin
            presc_d = presc_q + PRESC_BW'(1);
         end
      end else begin
         presc_d = presc_q;
      end

      if (step_s) begin
         tick_d = 1'b1;
         if (up_i) begin
            if (count_q < max_i) begin
               count_d = count_q + BW'(1);
            end else begin
               hit_s   = 1'b1;
               count_d = sat_i ? max_i : '0;
            end
         end else begin
            // A count stranded above a lowered max snaps down without a hit
            if (count_q > max_i) begin
               count_d = max_i;
            end else if (count_q != '0) begin
               count_d = count_q - BW'(1);
            end else begin
               hit_s   = 1'b1;
               count_d = sat_i ? '0 : max_i;
            end
         end
         wrap_d = hit_s;
      end else begin
         wrap_d = 1'b0;
      end

      ovf_d = hit_s | (ovf_q & ~clr_ovf_i);
   end

   // State register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         presc_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count_o = count_q;
   assign tick_o  = tick_q;
   assign wrap_o  = wrap_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboard bench for counter_mod: the driver queues hand-computed expected
// outputs per cycle, an independent monitor pops and compares after each edge.
module tb_counter_mod;

   logic       clk_i = 1'b0;
   logic       rst_i, en_i, up_i, sat_i, load_i, clr_ovf_i;
   logic [3:0] load_val_i, max_i, presc_i;
   logic [3:0] count_o;
   logic       tick_o, wrap_o, ovf_o;

   typedef struct {
      logic [3:0] c;
      logic       t;
      logic       w;
      logic       o;
      string      name;
   } exp_t;

   exp_t  exp_q[$];
   string phase = "init";
   int    n_checks = 0;
   int    n_fail   = 0;

   counter_mod #(.BW(4), .PRESC_BW(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .up_i(up_i), .sat_i(sat_i),
      .load_i(load_i), .load_val_i(load_val_i), .max_i(max_i), .presc_i(presc_i),
      .clr_ovf_i(clr_ovf_i), .count_o(count_o), .tick_o(tick_o),
      .wrap_o(wrap_o), .ovf_o(ovf_o)
   );

   always #5 clk_i = ~clk_i;

   // Queue the expected outputs after the coming edge, then step past it
   task automatic chk(input logic [3:0] c, input logic t, input logic w, input logic o);
      exp_t e;
      e.c = c; e.t = t; e.w = w; e.o = o; e.name = phase;
      exp_q.push_back(e);
      @(posedge clk_i);
      #2;
   endtask

   // Monitor: outputs are presented every cycle; compare 1 time unit after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (count_o !== e.c || tick_o !== e.t || wrap_o !== e.w || ovf_o !== e.o) begin
               n_fail++;
               $display("FAIL %s @%0t: got count=%0d tick=%b wrap=%b ovf=%b, expected count=%0d tick=%b wrap=%b ovf=%b",
                        e.name, $time, count_o, tick_o, wrap_o, ovf_o, e.c, e.t, e.w, e.o);
            end
         end
      end
   end

   // Global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; en_i = 1'b0; up_i = 1'b1; sat_i = 1'b0; load_i = 1'b0;
      clr_ovf_i = 1'b0; load_val_i = 4'd0; max_i = 4'd9; presc_i = 4'd0;

      phase = "reset";
      repeat (2) chk(4'd0, 1'b0, 1'b0, 1'b0);
      rst_i = 1'b0;
      phase = "hold";
      repeat (5) chk(4'd0, 1'b0, 1'b0, 1'b0);

      phase = "up_wrap";
      en_i = 1'b1;
      for (int k = 1; k <= 9; k++) chk(4'(k), 1'b1, 1'b0, 1'b0);
      chk(4'd0, 1'b1, 1'b1, 1'b1);
      chk(4'd1, 1'b1, 1'b0, 1'b1);
      chk(4'd2, 1'b1, 1'b0, 1'b1);

      phase = "down_sat";
      en_i = 1'b0; load_i = 1'b1; load_val_i = 4'd2;
      chk(4'd2, 1'b0, 1'b0, 1'b1);
      load_i = 1'b0; up_i = 1'b0; sat_i = 1'b1; en_i = 1'b1;
      chk(4'd1, 1'b1, 1'b0, 1'b1);
      chk(4'd0, 1'b1, 1'b0, 1'b1);
      chk(4'd0, 1'b1, 1'b1, 1'b1);
      chk(4'd0, 1'b1, 1'b1, 1'b1);
      phase = "clr_ovf";
      en_i = 1'b0; clr_ovf_i = 1'b1;
      chk(4'd0, 1'b0, 1'b0, 1'b0);
      phase = "set_beats_clr";
      en_i = 1'b1;
      chk(4'd0, 1'b1, 1'b1, 1'b1);
      en_i = 1'b0;
      chk(4'd0, 1'b0, 1'b0, 1'b0);
      clr_ovf_i = 1'b0;

      phase = "presc";
      up_i = 1'b1; sat_i = 1'b0; presc_i = 4'd3; en_i = 1'b1;
      for (int k = 1; k <= 12; k++) chk(4'(k / 4), (k % 4) == 0, 1'b0, 1'b0);
      phase = "presc_gap";
      repeat (2) chk(4'd3, 1'b0, 1'b0, 1'b0);
      en_i = 1'b0;
      repeat (2) chk(4'd3, 1'b0, 1'b0, 1'b0);
      en_i = 1'b1;
      chk(4'd3, 1'b0, 1'b0, 1'b0);
      chk(4'd4, 1'b1, 1'b0, 1'b0);

      phase = "load_clamp";
      en_i = 1'b0; presc_i = 4'd0; max_i = 4'd5; load_i = 1'b1; load_val_i = 4'd12;
      chk(4'd5, 1'b0, 1'b0, 1'b0);
      phase = "load_beats_step";
      en_i = 1'b1; load_val_i = 4'd3;
      chk(4'd3, 1'b0, 1'b0, 1'b0);
      load_i = 1'b0;
      chk(4'd4, 1'b1, 1'b0, 1'b0);
      phase = "rst_beats_load";
      rst_i = 1'b1; load_i = 1'b1; en_i = 1'b0;
      chk(4'd0, 1'b0, 1'b0, 1'b0);
      rst_i = 1'b0; load_i = 1'b0;

      phase = "shrink_up";
      max_i = 4'd9; load_i = 1'b1; load_val_i = 4'd8;
      chk(4'd8, 1'b0, 1'b0, 1'b0);
      load_i = 1'b0; max_i = 4'd4;
      chk(4'd8, 1'b0, 1'b0, 1'b0);
      en_i = 1'b1; up_i = 1'b1; sat_i = 1'b0;
      chk(4'd0, 1'b1, 1'b1, 1'b1);
      phase = "shrink_down";
      en_i = 1'b0; max_i = 4'd9; load_i = 1'b1;
      chk(4'd8, 1'b0, 1'b0, 1'b1);
      load_i = 1'b0; max_i = 4'd4; up_i = 1'b0; sat_i = 1'b1; en_i = 1'b1;
      chk(4'd4, 1'b1, 1'b0, 1'b1);

      phase = "max_zero";
      max_i = 4'd0; up_i = 1'b1; sat_i = 1'b0;
      chk(4'd0, 1'b1, 1'b1, 1'b1);
      sat_i = 1'b1;
      chk(4'd0, 1'b1, 1'b1, 1'b1);
      up_i = 1'b0;
      chk(4'd0, 1'b1, 1'b1, 1'b1);
      en_i = 1'b0; clr_ovf_i = 1'b1;
      chk(4'd0, 1'b0, 1'b0, 1'b0);
      clr_ovf_i = 1'b0;

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
      #2;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
